uart_reg_cmd_ctrl: RTL and testbench

Command sequencer between the UART byte receiver/transmitter and the 256 x 8-bit register bank. It parses the byte-level protocol: 'W' addr data writes a register; 'R' addr reads a register. It drives the bank's write/read-strobe interface with correct timing and returns one response byte per command over a valid/ready TX handshake. It also tracks protocol errors: unknown opcode, dropped byte, inter-byte timeout.

---
 rtl/uart_reg_cmd_ctrl.sv | 132 +++++++++++++
 tb/tb_uart_reg_cmd_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_cmd_ctrl.sv
// Byte-protocol sequencer between the UART and the 256x8 register bank.
// Parses 'W' addr data / 'R' addr, strobes the bank, returns one response byte per command.
module uart_reg_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  OP_WRITE       = 8'h57,
  parameter logic [7:0]  OP_READ        = 8'h52,
  parameter logic [7:0]  RSP_ACK        = 8'h4B,
  parameter logic [7:0]  RSP_NAK        = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       reg_write_en,
  output logic       reg_read_strobe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_write_data,
  input  logic [7:0] reg_read_data,
  output logic       busy,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, WRITE, READ, READ_WAIT, SEND
  } state_e;

  state_e      state_q;
  logic        opWrite_q;
  logic [7:0]  resp_q;
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  err_q;
  logic [7:0]  err_d;
  logic [31:0] tmo_q;

  logic inGet;
  logic tmoExpire;
  logic dropped;
  logic nak;
  logic errEvent;

  // At most one error source can fire per cycle since each is tied to a distinct state group.
  always_comb begin
    inGet     = (state_q == GET_ADDR) || (state_q == GET_DATA);
    tmoExpire = (TIMEOUT_CYCLES != 0) && inGet && !rx_valid &&
                (tmo_q == TIMEOUT_CYCLES - 1);
    dropped   = rx_valid && ((state_q == WRITE) || (state_q == READ) ||
                             (state_q == READ_WAIT) || (state_q == SEND));
    nak       = (state_q == IDLE) && rx_valid &&
                (rx_data != OP_WRITE) && (rx_data != OP_READ);
    errEvent  = nak || dropped || tmoExpire;
    err_d     = (errEvent && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      opWrite_q <= 1'b0;
      resp_q    <= 8'h00;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      err_q     <= 8'h00;
      tmo_q     <= '0;
    end else begin
      err_q <= err_d;
      case (state_q)
        IDLE: begin
          if (rx_valid) begin
            tmo_q <= '0;
            if (rx_data == OP_WRITE) begin
              opWrite_q <= 1'b1;
              state_q   <= GET_ADDR;
            end else if (rx_data == OP_READ) begin
              opWrite_q <= 1'b0;
              state_q   <= GET_ADDR;
            end else begin
              resp_q  <= RSP_NAK;
              state_q <= SEND;
            end
          end
        end
        GET_ADDR: begin
          if (rx_valid) begin
            addr_q  <= rx_data;
            tmo_q   <= '0;
            state_q <= opWrite_q ? GET_DATA : READ;
          end else if (tmoExpire) begin
            state_q <= IDLE;
          end else if (TIMEOUT_CYCLES != 0) begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        GET_DATA: begin
          if (rx_valid) begin
            wdata_q <= rx_data;
            tmo_q   <= '0;
            state_q <= WRITE;
          end else if (tmoExpire) begin
            state_q <= IDLE;
          end else if (TIMEOUT_CYCLES != 0) begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        WRITE: begin
          resp_q  <= RSP_ACK;
          state_q <= SEND;
        end
        READ:      state_q <= READ_WAIT;
        READ_WAIT: begin
          resp_q  <= reg_read_data;
          state_q <= SEND;
        end
        SEND:      if (tx_ready) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  // Bank strobes and TX valid come straight from the state register so they cannot glitch.
  assign tx_valid        = (state_q == SEND);
  assign tx_data         = resp_q;
  assign reg_write_en    = (state_q == WRITE);
  assign reg_read_strobe = (state_q == READ);
  assign reg_addr        = addr_q;
  assign reg_write_data  = wdata_q;
  assign busy            = (state_q != IDLE);
  assign err_count       = err_q;

endmodule

// File: tb/tb_uart_reg_cmd_ctrl.sv
// Scoreboard bench for uart_reg_cmd_ctrl with a behavioural register bank.
// Expected TX bytes, writes and read strobes are queued at stimulus time and checked on output.
module tb_uart_reg_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       reg_write_en;
  logic       reg_read_strobe;
  logic [7:0] reg_addr;
  logic [7:0] reg_write_data;
  logic [7:0] reg_read_data;
  logic       busy;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]  bank   [256];
  logic [7:0]  shadow [256];
  logic [7:0]  txExp [$];
  logic [15:0] wrExp [$];
  logic [7:0]  rdExp [$];
  logic [7:0]  errExp;
  logic        prevWe, prevRs;

  always #5 clk = ~clk;

  uart_reg_cmd_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .reg_write_en(reg_write_en), .reg_read_strobe(reg_read_strobe),
    .reg_addr(reg_addr), .reg_write_data(reg_write_data),
    .reg_read_data(reg_read_data),
    .busy(busy), .err_count(err_count)
  );

  // Register bank: writes land on the strobe edge, read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (reg_write_en) bank[reg_addr] <= reg_write_data;
    if (reg_read_strobe) reg_read_data <= bank[reg_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Output monitors run on the falling edge, away from DUT updates and TB input changes.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) begin
        checkOutput("tx_expected", txExp.size() != 0, 1);
        if (txExp.size() != 0) checkOutput("tx_data", tx_data, txExp.pop_front());
      end
      if (reg_write_en) begin
        checkOutput("we_one_cycle", prevWe, 0);
        checkOutput("wr_expected", wrExp.size() != 0, 1);
        if (wrExp.size() != 0) checkOutput("wr_addr_data", {reg_addr, reg_write_data}, wrExp.pop_front());
      end
      if (reg_read_strobe) begin
        checkOutput("rs_one_cycle", prevRs, 0);
        checkOutput("rd_expected", rdExp.size() != 0, 1);
        if (rdExp.size() != 0) checkOutput("rd_addr", reg_addr, rdExp.pop_front());
      end
    end
    prevWe = reg_write_en;
    prevRs = reg_read_strobe;
  end

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((busy || tx_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("wait_idle", busy, 0);
  endtask

  task automatic doWrite(input logic [7:0] a, input logic [7:0] d);
    wrExp.push_back({a, d});
    txExp.push_back(8'h4B);
    shadow[a] = d;
    applyStimulus(8'h57);
    applyStimulus(a);
    applyStimulus(d);
    waitIdle(20);
  endtask

  task automatic doRead(input logic [7:0] a);
    rdExp.push_back(a);
    txExp.push_back(shadow[a]);
    applyStimulus(8'h52);
    applyStimulus(a);
    waitIdle(20);
  endtask

  task automatic doNak();
    txExp.push_back(8'h3F);
    if (errExp != 8'hFF) errExp = errExp + 8'd1;
    applyStimulus(8'h41);
    waitIdle(20);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      bank[i]   = 8'h00;
      shadow[i] = 8'h00;
    end
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    prevWe = 1'b0; prevRs = 1'b0; errExp = 8'h00;
    idleCycles(2);
    rst = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst_tx_valid", tx_valid, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_we", reg_write_en, 0);
    checkOutput("rst_rs", reg_read_strobe, 0);
    checkOutput("rst_addr", reg_addr, 0);
    checkOutput("rst_wdata", reg_write_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err_count, 0);

    $display("[TB] write latency");
    wrExp.push_back(16'h10A5); txExp.push_back(8'h4B); shadow[8'h10] = 8'hA5;
    applyStimulus(8'h57); applyStimulus(8'h10); applyStimulus(8'hA5);
    checkOutput("wr_n1_we", reg_write_en, 1);
    checkOutput("wr_n1_txv", tx_valid, 0);
    idleCycles(1);
    checkOutput("wr_n2_txv", tx_valid, 1);
    checkOutput("wr_n2_txd", tx_data, 8'h4B);
    checkOutput("wr_n2_we", reg_write_en, 0);
    waitIdle(20);
    checkOutput("wr_hold_addr", reg_addr, 8'h10);
    checkOutput("wr_hold_data", reg_write_data, 8'hA5);

    $display("[TB] read latency");
    rdExp.push_back(8'h10); txExp.push_back(8'hA5);
    applyStimulus(8'h52); applyStimulus(8'h10);
    checkOutput("rd_n1_rs", reg_read_strobe, 1);
    idleCycles(1);
    checkOutput("rd_n2_rs", reg_read_strobe, 0);
    checkOutput("rd_n2_txv", tx_valid, 0);
    idleCycles(1);
    checkOutput("rd_n3_txv", tx_valid, 1);
    checkOutput("rd_n3_txd", tx_data, 8'hA5);
    waitIdle(20);

    doWrite(8'hFF, 8'h3C);
    doRead(8'hFF);
    doRead(8'h10);
    checkOutput("err_after_cmds", err_count, 0);

    $display("[TB] unknown opcode");
    doNak();
    checkOutput("err_nak", err_count, errExp);

    $display("[TB] backpressure");
    tx_ready = 1'b0;
    rdExp.push_back(8'h10); txExp.push_back(shadow[8'h10]);
    applyStimulus(8'h52); applyStimulus(8'h10);
    for (int n = 0; n < 10 && !tx_valid; n++) idleCycles(1);
    for (int i = 0; i < 50; i++) begin
      checkOutput("bp_txv", tx_valid, 1);
      checkOutput("bp_txd", tx_data, 8'hA5);
      rx_valid = (i == 10);
      rx_data  = 8'h52;
      idleCycles(1);
    end
    rx_valid = 1'b0;
    errExp = errExp + 8'd1;
    checkOutput("bp_err_drop", err_count, errExp);
    tx_ready = 1'b1;
    idleCycles(1);
    checkOutput("bp_txv_done", tx_valid, 0);
    checkOutput("bp_busy_done", busy, 0);

    $display("[TB] timeout");
    applyStimulus(8'h57);
    idleCycles(15);
    checkOutput("tmo_still_busy", busy, 1);
    idleCycles(1);
    errExp = errExp + 8'd1;
    checkOutput("tmo_idle", busy, 0);
    checkOutput("tmo_err", err_count, errExp);
    doRead(8'h00);
    wrExp.push_back(16'h2077); txExp.push_back(8'h4B); shadow[8'h20] = 8'h77;
    applyStimulus(8'h57);
    idleCycles(15);
    applyStimulus(8'h20);
    idleCycles(15);
    applyStimulus(8'h77);
    waitIdle(20);
    checkOutput("tmo_edge_err", err_count, errExp);
    doRead(8'h20);

    $display("[TB] reset mid-command");
    applyStimulus(8'h57); applyStimulus(8'h30);
    rst = 1'b1;
    idleCycles(1);
    rst = 1'b0;
    errExp = 8'h00;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_err", err_count, 0);
    doNak();
    checkOutput("midrst_nak_err", err_count, errExp);
    doRead(8'h30);

    $display("[TB] saturation");
    for (int i = 0; i < 300; i++) begin
      doNak();
      if (i == 253 || i == 254 || i == 299) checkOutput("sat_err", err_count, errExp);
    end
    checkOutput("sat_final", err_count, 8'hFF);

    idleCycles(3);
    checkOutput("txq_empty", txExp.size(), 0);
    checkOutput("wrq_empty", wrExp.size(), 0);
    checkOutput("rdq_empty", rdExp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
